// File: rtl/correlator_packetizer.sv
// correlator_packetizer
//
// Captures a snapshot of coincidence-counter words and streams it out as a
// byte frame to a UART-style byte sink with a valid/ready handshake:
//   SYNC_BYTE, sequence byte, payload (word 0 first, each word LSB byte
//   first, zero-padded to whole bytes), optional checksum byte.
//
// Build option: define CORRELATOR_PACKETIZER_CHECKSUM_EN to append a CHECK
// byte (sum mod 256 of the sequence byte and all payload bytes). Without it
// the last payload byte ends the frame.
//
// Ports:
//   clk           - clock, all state on the rising edge
//   reset_n       - asynchronous active-low reset
//   data_in       - counter snapshot, word k at data_in[k*RESOLUTION +: RESOLUTION]
//   snap_pulse    - one-cycle capture request
//   enable        - permits new captures
//   tx_ready      - byte sink can accept
//   tx_data       - byte offered
//   tx_valid      - tx_data is valid
//   busy          - a frame is in progress
//   overrun       - sticky, a snapshot was dropped
//   clear_overrun - synchronous clear of overrun (a same-cycle drop wins)
module correlator_packetizer #(
  parameter int         RESOLUTION = 8,
  parameter int         NUM_WORDS  = 36,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [RESOLUTION*NUM_WORDS-1:0] data_in,
  input  logic                            snap_pulse,
  input  logic                            enable,
  input  logic                            tx_ready,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  output logic                            busy,
  output logic                            overrun,
  input  logic                            clear_overrun
);

  localparam int BPW       = (RESOLUTION + 7) / 8;
  localparam int NUM_BYTES = NUM_WORDS * BPW;
  localparam int IDXW      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int PADW      = NUM_BYTES * 8;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAYLOAD, CHECK} state_t;

  state_t            state_q, state_d;
  logic [7:0]        seqNum_q, seqNum_d;
  logic [IDXW-1:0]   byteIdx_q, byteIdx_d;
  logic              overrun_q, overrun_d;
  logic [PADW-1:0]   snapBuf_q;
  logic [PADW-1:0]   snapPadded;
  logic [7:0]        payloadByte;
  logic              captureEn;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Spread each counter word onto a whole number of bytes so the payload
  // can be read out as a flat byte array; padding bits stay zero.
  always_comb begin
    snapPadded = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      snapPadded[k*BPW*8 +: RESOLUTION] = data_in[k*RESOLUTION +: RESOLUTION];
    end
  end

  // The byte index is widened by concatenation so the bit offset cannot
  // overflow the index width.
  assign payloadByte = snapBuf_q[{byteIdx_q, 3'b000} +: 8];

  // Snapshot buffer has no reset: its contents only matter once a capture
  // has loaded it.
  always_ff @(posedge clk) begin
    if (captureEn) begin
      snapBuf_q <= snapPadded;
    end
  end

  // Control state; reset returns to IDLE, which also forces the outputs low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      seqNum_q  <= 8'h00;
      byteIdx_q <= '0;
      overrun_q <= 1'b0;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      seqNum_q  <= seqNum_d;
      byteIdx_q <= byteIdx_d;
      overrun_q <= overrun_d;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Frame sequencer. Outputs are decoded from the registered state, so
  // tx_valid/tx_data are stable while the sink stalls and every byte advance
  // waits for tx_ready.
  always_comb begin
    state_d   = state_q;
    seqNum_d  = seqNum_q;
    byteIdx_d = byteIdx_q;
    captureEn = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b1;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (snap_pulse && enable) begin
          captureEn = 1'b1;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) state_d = SEQ;
      end
      SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seqNum_q;
        if (tx_ready) begin
          state_d   = PAYLOAD;
          byteIdx_d = '0;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
          csum_d    = seqNum_q;
`endif
        end
      end
      PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = payloadByte;
        if (tx_ready) begin
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
          csum_d = csum_q + payloadByte;
`endif
          if (byteIdx_q == LAST_IDX) begin
            byteIdx_d = '0;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
            state_d   = CHECK;
`else
            state_d   = IDLE;
            seqNum_d  = seqNum_q + 8'd1;
`endif
          end else begin
            byteIdx_d = byteIdx_q + 1'b1;
          end
        end
      end
      CHECK: begin
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) begin
          state_d  = IDLE;
          seqNum_d = seqNum_q + 8'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky drop flag: a snapshot request outside IDLE (including the cycle
  // of the final byte) is lost and flagged; a same-cycle clear loses.
  always_comb begin
    overrun_d = overrun_q;
    if (clear_overrun) overrun_d = 1'b0;
    if (snap_pulse && enable && (state_q != IDLE)) overrun_d = 1'b1;
  end

  assign overrun = overrun_q;

endmodule

// File: tb/tb_correlator_packetizer.sv
// Bench for correlator_packetizer: two instances (8-bit and 12-bit words)
// share the control inputs; sel picks which one is observed.
module tb_correlator_packetizer;

  localparam int NW   = 36;
  localparam int W8   = 8 * NW;
  localparam int W12  = 12 * NW;
  localparam int MAXW = W12;
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int LEN8  = 2 + NW + CSUM;
  localparam int LEN12 = 2 + 2 * NW + CSUM;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic snap_pulse = 1'b0;
  logic enable = 1'b0;
  logic tx_ready = 1'b0;
  logic clear_overrun = 1'b0;
  logic [W8-1:0]  data8 = '0;
  logic [W12-1:0] data12 = '0;
  logic sel = 1'b0;

  logic [7:0] txData8, txData12;
  logic txValid8, txValid12, busy8, busy12, over8, over12;

  logic [7:0] obsData;
  logic obsValid, obsBusy, obsOver;

  int checks = 0;
  int failures = 0;
  logic [7:0] tbSeq = 8'h00;
  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];

  correlator_packetizer #(.RESOLUTION(8), .NUM_WORDS(NW), .SYNC_BYTE(8'hA5)) dut8 (
    .clk(clk), .reset_n(reset_n), .data_in(data8), .snap_pulse(snap_pulse),
    .enable(enable), .tx_ready(tx_ready), .tx_data(txData8), .tx_valid(txValid8),
    .busy(busy8), .overrun(over8), .clear_overrun(clear_overrun));

  correlator_packetizer #(.RESOLUTION(12), .NUM_WORDS(NW), .SYNC_BYTE(8'hA5)) dut12 (
    .clk(clk), .reset_n(reset_n), .data_in(data12), .snap_pulse(snap_pulse),
    .enable(enable), .tx_ready(tx_ready), .tx_data(txData12), .tx_valid(txValid12),
    .busy(busy12), .overrun(over12), .clear_overrun(clear_overrun));

  assign obsData  = sel ? txData12  : txData8;
  assign obsValid = sel ? txValid12 : txValid8;
  assign obsBusy  = sel ? busy12    : busy8;
  assign obsOver  = sel ? over12    : over8;

  always #5 clk = ~clk;

  // Reference frame: sync, sequence, each word split LSB byte first, then
  // the optional mod-256 checksum over everything except the sync byte.
  function automatic void buildFrame(input logic [MAXW-1:0] data, input int res,
                                     input logic [7:0] seq);
    int bpw;
    int sum;
    logic [31:0] w;
    logic [7:0] b;
    bpw = (res + 7) / 8;
    expQ.delete();
    expQ.push_back(8'hA5);
    expQ.push_back(seq);
    sum = seq;
    for (int k = 0; k < NW; k++) begin
      w = '0;
      for (int j = 0; j < res; j++) w[j] = data[k*res + j];
      for (int i = 0; i < bpw; i++) begin
        b = 8'((w >> (8 * i)) & 32'hFF);
        expQ.push_back(b);
        sum = sum + b;
      end
    end
    if (CSUM == 1) expQ.push_back(8'(sum % 256));
  endfunction

  function automatic int firstDiff();
    int n;
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) if (gotQ[i] !== expQ[i]) return i;
    if (gotQ.size() != expQ.size()) return n;
    return -1;
  endfunction

  function automatic string diffMsg();
    int d;
    logic [7:0] g, e;
    d = firstDiff();
    g = (d >= 0 && d < gotQ.size()) ? gotQ[d] : 8'hxx;
    e = (d >= 0 && d < expQ.size()) ? expQ[d] : 8'hxx;
    return $sformatf("byte %0d got=%02h exp=%02h, got %0d bytes exp %0d bytes",
                     d, g, e, gotQ.size(), expQ.size());
  endfunction

  function automatic logic [MAXW-1:0] randData();
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW / 8; i++) r[i*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic doReset();
    @(negedge clk);
    snap_pulse = 1'b0; enable = 1'b0; tx_ready = 1'b0; clear_overrun = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tbSeq = 8'h00;
  endtask

  // Starts a frame, then collects transferred bytes until tx_valid drops.
  // readyMode: 0 always ready, 1 toggling, 2 random. At iteration injectAt
  // a second snap_pulse (with chosen enable/clear) and new data_in are applied.
  task automatic applyStimulus(input int readyMode, input int injectAt,
                               input logic injEnable, input logic injClear,
                               output int busyCycles);
    logic r;
    logic prevStall;
    logic [7:0] prevData;
    int stallErr;
    bit done;
    gotQ.delete();
    busyCycles = 0; stallErr = 0; done = 0; prevStall = 0; prevData = 8'h00;
    @(negedge clk);
    snap_pulse = 1'b1; enable = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    snap_pulse = 1'b0; enable = 1'b0;
    checks++;
    if (obsValid !== 1'b1 || obsData !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL sync_latency: valid=%b data=%02h, required valid=1 data=a5", obsValid, obsData);
    end
    for (int i = 0; i < 2000; i++) begin
      if (obsBusy === 1'b1) busyCycles++;
      if (obsValid !== 1'b1) begin done = 1; break; end
      if (prevStall && obsData !== prevData) stallErr++;
      case (readyMode)
        0: r = 1'b1;
        1: r = (i % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      tx_ready = r;
      snap_pulse = (i == injectAt);
      enable = (i == injectAt) ? injEnable : 1'b0;
      clear_overrun = (i == injectAt) ? injClear : 1'b0;
      if (i == injectAt) begin
        data8 = W8'(randData());
        data12 = randData();
      end
      if (r) gotQ.push_back(obsData);
      prevStall = !r;
      prevData = obsData;
      @(negedge clk);
    end
    snap_pulse = 1'b0; enable = 1'b0; clear_overrun = 1'b0; tx_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL frame_timeout: tx_valid still %b after 2000 cycles, required 0", obsValid);
    end
    if (readyMode != 0) begin
      checks++;
      if (stallErr !== 0) begin
        failures++;
        $display("[TB] FAIL stall_stable: %0d changes of tx_data while stalled, required 0", stallErr);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obsValid !== 1'b0 || obsData !== 8'h00 || obsBusy !== 1'b0 || obsOver !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: valid=%b data=%02h busy=%b overrun=%b, required 0/00/0/0",
               obsValid, obsData, obsBusy, obsOver);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obsValid !== 1'b0 || obsBusy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset: valid=%b busy=%b, required 0/0", obsValid, obsBusy);
    end
  endtask

  task automatic test_basic_frame();
    int bc;
    logic [MAXW-1:0] d;
    for (int k = 0; k < NW; k++) data8[k*8 +: 8] = 8'(k + 1);
    d = MAXW'(data8);
    buildFrame(d, 8, tbSeq);
    applyStimulus(0, -1, 1'b0, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL basic_frame: %s", diffMsg());
    end
    checks++;
    if (bc != LEN8) begin
      failures++;
      $display("[TB] FAIL basic_busy: busy for %0d cycles, required %0d", bc, LEN8);
    end
`ifdef CORRELATOR_PACKETIZER_CHECKSUM_EN
    checks++;
    if (gotQ.size() != LEN8 || gotQ[LEN8-1] !== 8'h9A) begin
      failures++;
      $display("[TB] FAIL basic_check_byte: got %02h, required 9a",
               (gotQ.size() == LEN8) ? gotQ[LEN8-1] : 8'hxx);
    end
`endif
    tbSeq++;
  endtask

  task automatic test_stall_frame();
    int bc;
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(1, -1, 1'b0, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL toggle_frame: %s", diffMsg());
    end
    tbSeq++;
    data8 = W8'(randData());
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(2, -1, 1'b0, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL random_ready_frame: %s", diffMsg());
    end
    tbSeq++;
  endtask

  task automatic checkOutput(input string name, input logic expOver, input logic expBusy);
    checks++;
    if (obsOver !== expOver || obsBusy !== expBusy) begin
      failures++;
      $display("[TB] FAIL %s: overrun=%b busy=%b, required overrun=%b busy=%b",
               name, obsOver, obsBusy, expOver, expBusy);
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
  endtask

  task automatic test_overrun();
    int bc;
    data8 = W8'(randData());
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(2, 5, 1'b1, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL overrun_frame: %s", diffMsg());
    end
    tbSeq++;
    checkOutput("overrun_set", 1'b1, 1'b0);
    pulseClear();
    checkOutput("overrun_clear", 1'b0, 1'b0);
    // drop and clear in the same cycle: the drop wins
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(0, 3, 1'b1, 1'b1, bc);
    tbSeq++;
    checkOutput("overrun_set_wins", 1'b1, 1'b0);
    pulseClear();
    // snap with enable low while busy: no overrun
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(0, 3, 1'b0, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL disabled_snap_frame: %s", diffMsg());
    end
    tbSeq++;
    checkOutput("disabled_no_overrun", 1'b0, 1'b0);
    // snap in the cycle of the last byte transfer is dropped
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(0, LEN8 - 1, 1'b1, 1'b0, bc);
    tbSeq++;
    checkOutput("last_byte_overrun", 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("last_byte_no_frame", 1'b1, 1'b0);
    pulseClear();
    // snap in IDLE with enable low starts nothing
    @(negedge clk);
    snap_pulse = 1'b1; enable = 1'b0;
    @(negedge clk);
    snap_pulse = 1'b0;
    checkOutput("idle_disabled_ignored", 1'b0, 1'b0);
  endtask

  task automatic test_seq_wrap();
    int bc;
    int bad;
    int firstBad;
    string msg;
    doReset();
    bad = 0; firstBad = -1; msg = "";
    for (int f = 0; f < 257; f++) begin
      data8 = W8'(randData());
      buildFrame(MAXW'(data8), 8, tbSeq);
      applyStimulus(0, -1, 1'b0, 1'b0, bc);
      if (firstDiff() != -1) begin
        bad++;
        if (firstBad < 0) begin firstBad = f; msg = diffMsg(); end
      end
      tbSeq++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL seq_wrap: %0d of 257 frames wrong, first frame %0d: %s, required 0 wrong",
               bad, firstBad, msg);
    end
  endtask

  task automatic test_reset_midframe();
    int bc;
    @(negedge clk);
    data8 = W8'(randData());
    snap_pulse = 1'b1; enable = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    snap_pulse = 1'b0; enable = 1'b0;
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (txValid8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_abort: valid=%b busy=%b, required 0/0", txValid8, busy8);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tx_ready = 1'b0;
    tbSeq = 8'h00;
    @(negedge clk);
    checks++;
    if (txValid8 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_no_resume: valid=%b, required 0", txValid8);
    end
    data8 = W8'(randData());
    buildFrame(MAXW'(data8), 8, tbSeq);
    applyStimulus(0, -1, 1'b0, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL after_reset_frame: %s", diffMsg());
    end
    tbSeq++;
  endtask

  task automatic test_resolution12();
    int bc;
    doReset();
    sel = 1'b1;
    data12 = randData();
    data12[11:0] = 12'hABC;
    buildFrame(MAXW'(data12), 12, 8'h00);
    applyStimulus(0, -1, 1'b0, 1'b0, bc);
    checks++;
    if (firstDiff() != -1) begin
      failures++;
      $display("[TB] FAIL res12_frame: %s", diffMsg());
    end
    checks++;
    if (gotQ.size() < 4 || gotQ[2] !== 8'hBC || gotQ[3] !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL res12_word0: got %0d bytes, bytes2/3=%02h,%02h, required bc,0a",
               gotQ.size(), (gotQ.size() > 2) ? gotQ[2] : 8'hxx, (gotQ.size() > 3) ? gotQ[3] : 8'hxx);
    end
    checks++;
    if (gotQ.size() != LEN12) begin
      failures++;
      $display("[TB] FAIL res12_length: %0d bytes, required %0d", gotQ.size(), LEN12);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall_frame();
    test_overrun();
    test_reset_midframe();
    test_seq_wrap();
    test_resolution12();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/correlator_packetizer.md
CORRELATOR_PACKETIZER -- requirements
Module: correlator_packetizer

Interface
REQ-001 SHALL have parameter RESOLUTION, default 8: bit width of one counter word.
REQ-002 SHALL have parameter NUM_WORDS, default 36: number of counter words per snapshot (28 pair counts plus 8 single counts).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port data_in, input, RESOLUTION*NUM_WORDS: counter snapshot; word k is data_in[k*RESOLUTION +: RESOLUTION].
REQ-007 SHALL have port snap_pulse, input, 1: one-cycle strobe requesting capture of data_in (the integration-end pulse).
REQ-008 SHALL have port enable, input, 1: permits new captures.
REQ-009 SHALL have port tx_ready, input, 1: downstream UART byte sink can accept.
REQ-010 SHALL have port tx_data, output, 8: byte offered.
REQ-011 SHALL have port tx_valid, output, 1: tx_data valid.
REQ-012 SHALL have port busy, output, 1: a frame is in progress.
REQ-013 SHALL have port overrun, output, 1: sticky flag, a snapshot was dropped.
REQ-014 SHALL have port clear_overrun, input, 1: synchronous clear of overrun.

Function
REQ-015 SHALL use FSM states IDLE, SYNC, SEQ, PAYLOAD, CHECK.
REQ-016 SHALL, in IDLE with snap_pulse=1 and enable=1, register all of data_in into an internal snapshot buffer and move to SYNC on the next edge.
REQ-017 SHALL assert tx_valid with tx_data=SYNC_BYTE in the cycle after the accepting snap_pulse (latency 1).
REQ-018 SHALL transfer a byte only on a cycle with tx_valid=1 and tx_ready=1; tx_data and tx_valid stay stable until then.
REQ-019 SHALL emit the frame in this order: SYNC_BYTE, the sequence byte, then the payload.
REQ-020 SHALL build the payload from word 0 to word NUM_WORDS-1, each word as BPW=(RESOLUTION+7)/8 bytes, least-significant byte first, with unused upper bits zero-padded.
REQ-021 SHALL hold tx_valid high continuously through a frame, so that back-to-back ready gives one byte per cycle.
REQ-022 SHALL increment the 8-bit sequence counter by 1 after the last byte of each frame transfers, wrapping 255->0; the first frame after reset carries 0.
REQ-023 SHALL return to IDLE after the final byte transfers, with tx_valid=0 in the following cycle.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL ignore a snap_pulse when not IDLE, leave the frame and buffer unchanged, and set overrun=1.
REQ-026 SHALL set overrun when a snap_pulse and clear_overrun occur in the same cycle (set wins).
REQ-027 SHALL ignore snap_pulse while enable=0, without setting overrun.
REQ-028 SHALL complete an in-progress frame even if enable is deasserted mid-frame.
REQ-029 SHALL treat a snap_pulse in the same cycle as the last byte transfer as arriving while busy, so it is dropped and sets overrun.

Reset
REQ-030 SHALL, while reset_n=0, immediately force state=IDLE, tx_valid=0, tx_data=8'h00, busy=0, overrun=0, sequence=0, byte index=0, and checksum accumulator=0.
REQ-031 SHALL, on reset asserted mid-frame, abort the frame with no further bytes emitted and leave the snapshot buffer contents don't-care.

Configuration
REQ-032 SHALL, with macro CORRELATOR_PACKETIZER_CHECKSUM_EN defined, append one CHECK byte after the payload, equal to the sum modulo 256 of the sequence byte and all payload bytes (SYNC excluded); frame length is 3+NUM_WORDS*BPW.
REQ-033 SHALL, without that macro, skip state CHECK and make the last payload byte end the frame; frame length is 2+NUM_WORDS*BPW.

Verification
REQ-034 Bench SHALL cover: defaults, data_in word k=k+1, tx_ready held 1, CHECKSUM_EN defined -> A5,00,01..24,CHECK=8'h9A; busy for 39 cycles.
REQ-035 Bench SHALL cover: same frame with tx_ready toggling 1/0 each cycle -> identical byte sequence; tx_data stable across stalled cycles.
REQ-036 Bench SHALL cover: second snap_pulse 5 cycles into a frame -> frame unchanged, overrun=1; clear_overrun pulse -> overrun=0 next cycle.
REQ-037 Bench SHALL cover: 256 consecutive frames -> sequence bytes 00..FF, then 00 on frame 257.
REQ-038 Bench SHALL cover: reset_n low during PAYLOAD byte 10 -> tx_valid=0 immediately; next snap_pulse yields a frame starting A5,00.
REQ-039 Bench SHALL cover: RESOLUTION=12, word0=12'hABC, macro undefined -> payload begins BC,0A; no CHECK byte.
